// File: rtl/axis_dac_spi_out_if.sv
// Stream bundle carrying the six Q31 control channels into the DAC output stage.
//   tdata  : NUM_CH*32 packed channel words, CH1 in bits [31:0]
//   tvalid : one valid bit per channel
// master drives the bundle, slave (the DAC stage) samples it.
interface axis_dac_spi_out_if #(
  parameter int unsigned NUM_CH = 6
) ();
  logic [NUM_CH*32-1:0] tdata;
  logic [NUM_CH-1:0]    tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/axis_dac_spi_out.sv
// Coherent six-channel DAC output stage. Once per frame the channel inputs are
// snapshotted into hold registers, converted to DAC codes and shifted out MSB
// first over one daisy-chained SPI link (CH6 word first), followed by a single
// LDAC pulse so every DAC updates on the same cycle.
//
// Optional feature macro: DAC_ROUND_EN
//   defined   : round to nearest (add half LSB) and saturate positive overflow
//   undefined : plain truncation toward minus infinity
//
// Ports
//   a_clk, a_rst  : clock, asynchronous active-high reset
//   S_AXIS        : slave modport, tdata (NUM_CH*32) / tvalid (NUM_CH)
//   enable        : run frames back to back while high
//   dac_sclk      : SPI clock, high for the first half of each bit cell
//   dac_sdo       : SPI data, changes when dac_sclk rises
//   dac_sync_n    : chain frame select, low during the shift phase
//   dac_ldac_n    : simultaneous update strobe
//   busy          : high whenever a frame is in progress
//   frame_done    : one-cycle pulse in the last LDAC cycle
//   frame_count   : completed frames, wraps
module axis_dac_spi_out #(
  parameter int unsigned NUM_CH   = 6,
  parameter int unsigned DAC_BITS = 20,
  parameter int unsigned SCLK_DIV = 2,
  parameter int unsigned SYNC_GAP = 4,
  parameter int unsigned LDAC_W   = 2
) (
  input  logic                  a_clk,
  input  logic                  a_rst,
  axis_dac_spi_out_if.slave     S_AXIS,
  input  logic                  enable,
  output logic                  dac_sclk,
  output logic                  dac_sdo,
  output logic                  dac_sync_n,
  output logic                  dac_ldac_n,
  output logic                  busy,
  output logic                  frame_done,
  output logic [31:0]           frame_count
);

  localparam int unsigned WORD_W  = 24;
  localparam int unsigned SR_W    = NUM_CH * WORD_W;
  localparam int unsigned CELL    = 2 * SCLK_DIV;
  localparam int unsigned PH_W    = $clog2(CELL);
  localparam int unsigned BIT_W   = $clog2(SR_W);
  localparam int unsigned CNT_MAX = (SYNC_GAP > LDAC_W) ? SYNC_GAP : LDAC_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned SHAMT   = 32 - DAC_BITS;
  localparam int unsigned PAD     = 20 - DAC_BITS;

`ifdef DAC_ROUND_EN
  localparam logic [32:0]        RND      = 33'(1) << (31 - DAC_BITS);
  localparam logic signed [32:0] CODE_MAX = 33'((33'(1) << (DAC_BITS - 1)) - 33'(1));
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LDAC} state_t;

  // Q31 sample to two's-complement DAC code
  function automatic logic [DAC_BITS-1:0] to_code(input logic [31:0] x);
`ifdef DAC_ROUND_EN
    logic signed [32:0] sum;
    logic signed [32:0] shifted;
    sum     = $signed({x[31], x}) + $signed(RND);
    shifted = sum >>> SHAMT;
    // Only the positive side can overflow since the half-LSB adder is positive
    if (shifted > CODE_MAX) to_code = DAC_BITS'(CODE_MAX);
    else                    to_code = DAC_BITS'(shifted);
`else
    logic signed [31:0] xs;
    xs      = $signed(x);
    to_code = DAC_BITS'(xs >>> SHAMT);
`endif
  endfunction

  // Write-DAC-register command with the code left-justified in the 20-bit field
  function automatic logic [WORD_W-1:0] to_word(input logic [31:0] x);
    logic [19:0] field;
    field   = 20'(to_code(x)) << PAD;
    to_word = {4'b0001, field};
  endfunction

  state_t                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SR_W-1:0]        sreg_q, sreg_d;
  logic [NUM_CH*32-1:0]   hold_q, hold_d;

  logic                   sclk_q, sclk_d;
  logic                   sdo_q, sdo_d;
  logic                   sync_n_q, sync_n_d;
  logic                   ldac_n_q, ldac_n_d;
  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [31:0]            frame_count_q, frame_count_d;

  // State and datapath registers
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      sreg_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      hold_q  <= hold_d;
    end
  end

  // Next state, snapshot and shift sequencing
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        // Channels without tvalid reuse the previous frame's sample
        for (int i = 0; i < int'(NUM_CH); i++) begin
          if (S_AXIS.tvalid[i]) hold_d[i*32 +: 32] = S_AXIS.tdata[i*32 +: 32];
        end
        // CH1 lands in the low word so it is shifted out last
        for (int i = 0; i < int'(NUM_CH); i++) begin
          sreg_d[i*WORD_W +: WORD_W] = to_word(hold_d[i*32 +: 32]);
        end
        phase_d = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (phase_q == PH_W'(CELL - 1)) begin
          phase_d = '0;
          if (bit_q == BIT_W'(SR_W - 1)) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sreg_d = {sreg_q[SR_W-2:0], 1'b0};
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(SYNC_GAP - 1)) begin
          cnt_d   = '0;
          state_d = LDAC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LDAC: begin
        // enable is only honoured here, so frames are never cut short
        if (cnt_q == CNT_W'(LDAC_W - 1)) state_d = enable ? LOAD : IDLE;
        else                              cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered pins line up with it
  always_comb begin
    sclk_d        = 1'b0;
    sdo_d         = 1'b0;
    sync_n_d      = 1'b1;
    ldac_n_d      = 1'b1;
    busy_d        = (state_d != IDLE);
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    case (state_d)
      SHIFT: begin
        sync_n_d = 1'b0;
        sclk_d   = (phase_d < PH_W'(SCLK_DIV));
        sdo_d    = sreg_d[SR_W-1];
      end
      LDAC: begin
        ldac_n_d = 1'b0;
        if (cnt_d == CNT_W'(LDAC_W - 1)) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      sclk_q        <= 1'b0;
      sdo_q         <= 1'b0;
      sync_n_q      <= 1'b1;
      ldac_n_q      <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      sclk_q        <= sclk_d;
      sdo_q         <= sdo_d;
      sync_n_q      <= sync_n_d;
      ldac_n_q      <= ldac_n_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_sdo     = sdo_q;
  assign dac_sync_n  = sync_n_q;
  assign dac_ldac_n  = ldac_n_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_dac_spi_out.sv
// Self-checking bench for axis_dac_spi_out: random channel data, a
// behavioural word/frame model and a pin-level SPI monitor.
module tb_axis_dac_spi_out;

  localparam int NUM_CH   = 6;
  localparam int DAC_BITS = 20;
  localparam int SCLK_DIV = 2;
  localparam int SYNC_GAP = 4;
  localparam int LDAC_W   = 2;
  localparam int NBITS    = 144;

  logic        a_clk;
  logic        a_rst;
  logic        enable;
  logic        dac_sclk, dac_sdo, dac_sync_n, dac_ldac_n, busy, frame_done;
  logic [31:0] frame_count;

  axis_dac_spi_out_if #(.NUM_CH(NUM_CH)) s_axis ();

  axis_dac_spi_out #(
    .NUM_CH(NUM_CH), .DAC_BITS(DAC_BITS), .SCLK_DIV(SCLK_DIV),
    .SYNC_GAP(SYNC_GAP), .LDAC_W(LDAC_W)
  ) dut (
    .a_clk(a_clk), .a_rst(a_rst), .S_AXIS(s_axis), .enable(enable),
    .dac_sclk(dac_sclk), .dac_sdo(dac_sdo), .dac_sync_n(dac_sync_n),
    .dac_ldac_n(dac_ldac_n), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_hold [NUM_CH];

  // Pin monitor state (written only by the monitor process)
  int   cyc = 0;
  bit   bits [$];
  int   sync_falls = 0, ldac_falls = 0, done_cnt = 0, busy_rises = 0, busy_falls = 0;
  int   sync_low_total = 0, ldac_low_total = 0, sdo_unstable = 0, sclk_stray = 0;
  int   busy_rise_cyc = 0, sync_fall_cyc = 0, ldac_fall_cyc = 0, done_cyc = 0;
  logic p_sclk = 1'b0, p_sync = 1'b1, p_ldac = 1'b1, p_busy = 1'b0, hi_sdo = 1'b0;

  initial forever begin
    @(negedge a_clk);
    cyc++;
    if (dac_sclk) hi_sdo = dac_sdo;
    if (p_sclk && !dac_sclk && !dac_sync_n) begin
      bits.push_back(dac_sdo);
      if (dac_sdo !== hi_sdo) sdo_unstable++;
    end
    if (dac_sclk && dac_sync_n) sclk_stray++;
    if (p_sync && !dac_sync_n) begin sync_falls++; sync_fall_cyc = cyc; end
    if (!dac_sync_n) sync_low_total++;
    if (p_ldac && !dac_ldac_n) begin ldac_falls++; ldac_fall_cyc = cyc; end
    if (!dac_ldac_n) ldac_low_total++;
    if (!p_busy && busy) begin busy_rises++; busy_rise_cyc = cyc; end
    if (p_busy && !busy) busy_falls++;
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    p_sclk = dac_sclk; p_sync = dac_sync_n; p_ldac = dac_ldac_n; p_busy = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  // Expected 24-bit word: floor(value / 2^(32-DAC_BITS)), optional round + clamp
  function automatic logic [23:0] model_word(input logic [31:0] x);
    longint v, step, q;
`ifdef DAC_ROUND_EN
    longint lim;
`endif
    v    = longint'($signed(x));
    step = longint'(1) << (32 - DAC_BITS);
`ifdef DAC_ROUND_EN
    v = v + step / 2;
`endif
    q = v / step;
    if ((v % step) != 0 && v < 0) q = q - 1;
`ifdef DAC_ROUND_EN
    lim = (longint'(1) << (DAC_BITS - 1)) - 1;
    if (q > lim) q = lim;
`endif
    q = q & ((longint'(1) << DAC_BITS) - 1);
    return 24'((longint'(1) << 20) | (q << (20 - DAC_BITS)));
  endfunction

  function automatic logic [143:0] model_frame();
    logic [143:0] f;
    for (int ch = 0; ch < NUM_CH; ch++) f[ch*24 +: 24] = model_word(m_hold[ch]);
    return f;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge a_clk); #1; end
  endtask

  task automatic wait_sync_fall(input int limit, output bit ok);
    int s;
    s = sync_falls; ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin tick(1); if (sync_falls != s) ok = 1'b1; end
  endtask

  task automatic wait_ldac_fall(input int limit, output bit ok);
    int s;
    s = ldac_falls; ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin tick(1); if (ldac_falls != s) ok = 1'b1; end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin tick(1); if (!busy) ok = 1'b1; end
  endtask

  task automatic wait_bits(input int start, input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin tick(1); if (bits.size() - start >= n) ok = 1'b1; end
  endtask

  function automatic logic [143:0] assemble(input int start);
    logic [143:0] g;
    g = '0;
    for (int k = 0; k < NBITS; k++)
      if (start + k < bits.size()) g = {g[142:0], bits[start+k]};
    return g;
  endfunction

  function automatic logic [NUM_CH*32-1:0] rand_data();
    logic [NUM_CH*32-1:0] d;
    for (int ch = 0; ch < NUM_CH; ch++) d[ch*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) m_hold[ch] = '0;
  endtask

  // Presents one frame's inputs, scrambles them once shifting starts and
  // returns the captured bits once LDAC falls (and idle if enable is dropped)
  task automatic do_frame(input logic [NUM_CH*32-1:0] data, input logic [NUM_CH-1:0] valid,
                          input bit keep_en, output logic [143:0] got, output int nbits,
                          output bit ok);
    int start;
    bit ok1, ok2, ok3;
    s_axis.tdata  = data;
    s_axis.tvalid = valid;
    enable        = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) if (valid[ch]) m_hold[ch] = data[ch*32 +: 32];
    wait_sync_fall(20, ok1);
    start = bits.size();
    s_axis.tdata  = rand_data();
    s_axis.tvalid = NUM_CH'($urandom());
    if (!keep_en) enable = 1'b0;
    wait_ldac_fall(700, ok2);
    nbits = bits.size() - start;
    got   = assemble(start);
    ok3   = 1'b1;
    if (!keep_en) wait_idle(10, ok3);
    ok = ok1 && ok2 && ok3;
  endtask

  task automatic apply_reset();
    a_rst = 1'b1; enable = 1'b0;
    tick(3);
    a_rst = 1'b0;
    model_reset();
    tick(2);
  endtask

  task automatic test_reset();
    int sf;
    a_rst = 1'b1; enable = 1'b0;
    s_axis.tdata = rand_data(); s_axis.tvalid = '1;
    tick(3);
    n_tests++; if (dac_sclk !== 1'b0)   begin n_fail++; $display("FAIL reset_sclk got %b want 0", dac_sclk); end
    n_tests++; if (dac_sdo !== 1'b0)    begin n_fail++; $display("FAIL reset_sdo got %b want 0", dac_sdo); end
    n_tests++; if (dac_sync_n !== 1'b1) begin n_fail++; $display("FAIL reset_sync_n got %b want 1", dac_sync_n); end
    n_tests++; if (dac_ldac_n !== 1'b1) begin n_fail++; $display("FAIL reset_ldac_n got %b want 1", dac_ldac_n); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    n_tests++; if (frame_count !== 32'd0) begin n_fail++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
    a_rst = 1'b0;
    model_reset();
    sf = sync_falls;
    tick(20);
    n_tests++; if (sync_falls != sf || busy !== 1'b0)
      begin n_fail++; $display("FAIL idle_no_enable sync_falls +%0d busy %b want +0 and 0", sync_falls - sf, busy); end
  endtask

  task automatic test_zero_frame();
    logic [143:0] got, exp_c;
    int nb, sl, ll, dc;
    bit ok;
    sl = sync_low_total; ll = ldac_low_total; dc = done_cnt;
    do_frame('0, '1, 1'b0, got, nb, ok);
    exp_c = {6{24'h100000}};
    n_tests++; if (!ok) begin n_fail++; $display("FAIL zero_timeout ok %b want 1", ok); end
    n_tests++; if (nb != NBITS) begin n_fail++; $display("FAIL zero_nbits got %0d want %0d", nb, NBITS); end
    n_tests++; if (got !== exp_c) begin n_fail++; $display("FAIL zero_bits got %h want %h", got, exp_c); end
    n_tests++; if (sync_low_total - sl != 576) begin n_fail++; $display("FAIL zero_sync_low got %0d want 576", sync_low_total - sl); end
    n_tests++; if (ldac_low_total - ll != LDAC_W) begin n_fail++; $display("FAIL zero_ldac_low got %0d want %0d", ldac_low_total - ll, LDAC_W); end
    n_tests++; if (sync_fall_cyc - busy_rise_cyc != 1) begin n_fail++; $display("FAIL zero_sync_lat got %0d want 1", sync_fall_cyc - busy_rise_cyc); end
    n_tests++; if (ldac_fall_cyc - busy_rise_cyc != 581) begin n_fail++; $display("FAIL zero_ldac_lat got %0d want 581", ldac_fall_cyc - busy_rise_cyc); end
    n_tests++; if (done_cyc - busy_rise_cyc != 582) begin n_fail++; $display("FAIL zero_done_lat got %0d want 582", done_cyc - busy_rise_cyc); end
    n_tests++; if (done_cnt - dc != 1) begin n_fail++; $display("FAIL zero_done_pulses got %0d want 1", done_cnt - dc); end
    n_tests++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL zero_frame_count got %0d want 1", frame_count); end
    n_tests++; if (sdo_unstable != 0 || sclk_stray != 0)
      begin n_fail++; $display("FAIL zero_pin_rules unstable %0d stray %0d want 0 0", sdo_unstable, sclk_stray); end
  endtask

  task automatic test_ordering();
    logic [NUM_CH*32-1:0] d;
    logic [143:0] got, exp;
    int nb;
    bit ok;
    d = '0;
    d[31:0]    = 32'h4000_0000;
    d[191:160] = 32'hC000_0000;
    do_frame(d, '1, 1'b0, got, nb, ok);
    exp = model_frame();
    n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL order_frame got %h want %h ok %b", got, exp, ok); end
    n_tests++; if (got[143:120] !== 24'h1C0000) begin n_fail++; $display("FAIL order_first_word got %h want 1c0000", got[143:120]); end
    n_tests++; if (got[23:0] !== 24'h140000) begin n_fail++; $display("FAIL order_last_word got %h want 140000", got[23:0]); end
  endtask

  task automatic test_rounding();
    logic [NUM_CH*32-1:0] d;
    logic [143:0] got, exp;
    logic [23:0] want_small;
    int nb;
    bit ok;
    d = rand_data();
    d[95:64] = 32'h7FFF_FFFF;
    do_frame(d, '1, 1'b0, got, nb, ok);
    exp = model_frame();
    n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL round_max_frame got %h want %h", got, exp); end
    n_tests++; if (got[71:48] !== 24'h17FFFF) begin n_fail++; $display("FAIL round_max_word got %h want 17ffff", got[71:48]); end
    d = rand_data();
    d[95:64]  = 32'h0000_0800;
    d[127:96] = 32'hFFFF_F800;
`ifdef DAC_ROUND_EN
    want_small = 24'h100001;
`else
    want_small = 24'h100000;
`endif
    do_frame(d, '1, 1'b0, got, nb, ok);
    exp = model_frame();
    n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL round_small_frame got %h want %h", got, exp); end
    n_tests++; if (got[71:48] !== want_small) begin n_fail++; $display("FAIL round_small_word got %h want %h", got[71:48], want_small); end
  endtask

  task automatic test_hold();
    logic [143:0] got, exp;
    logic [23:0] prev3;
    int nb;
    bit ok;
    do_frame(rand_data(), '1, 1'b0, got, nb, ok);
    prev3 = got[71:48];
    exp = model_frame();
    n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL hold_first got %h want %h", got, exp); end
    do_frame(rand_data(), 6'b111011, 1'b0, got, nb, ok);
    exp = model_frame();
    n_tests++; if (!ok || got !== exp) begin n_fail++; $display("FAIL hold_second got %h want %h", got, exp); end
    n_tests++; if (got[71:48] !== prev3) begin n_fail++; $display("FAIL hold_ch3_repeat got %h want %h", got[71:48], prev3); end
  endtask

  task automatic test_back_to_back();
    logic [143:0] got, exp;
    int nb, bf, fc0, prev_sf;
    bit ok;
    bf = busy_falls; fc0 = frame_count; prev_sf = 0;
    for (int f = 0; f < 4; f++) begin
      do_frame(rand_data(), NUM_CH'($urandom()), (f != 3), got, nb, ok);
      exp = model_frame();
      n_tests++; if (!ok || nb != NBITS || got !== exp)
        begin n_fail++; $display("FAIL b2b_frame%0d got %h want %h nbits %0d", f, got, exp, nb); end
      if (f > 0) begin
        n_tests++; if (sync_fall_cyc - prev_sf != 583)
          begin n_fail++; $display("FAIL b2b_spacing%0d got %0d want 583", f, sync_fall_cyc - prev_sf); end
      end
      prev_sf = sync_fall_cyc;
    end
    n_tests++; if (busy_falls - bf != 1) begin n_fail++; $display("FAIL b2b_busy_falls got %0d want 1", busy_falls - bf); end
    n_tests++; if (frame_count - fc0 != 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", frame_count - fc0); end
  endtask

  task automatic test_enable_drop();
    logic [NUM_CH*32-1:0] d;
    logic [143:0] got, exp;
    int start, lf, dc, sf;
    bit ok1, ok2, ok3, ok4;
    d = rand_data();
    s_axis.tdata = d; s_axis.tvalid = '1; enable = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) m_hold[ch] = d[ch*32 +: 32];
    lf = ldac_falls; dc = done_cnt;
    wait_sync_fall(20, ok1);
    start = bits.size();
    wait_bits(start, 50, 300, ok2);
    enable = 1'b0;
    s_axis.tdata = rand_data();
    wait_ldac_fall(700, ok3);
    got = assemble(start);
    exp = model_frame();
    wait_idle(10, ok4);
    n_tests++; if (!(ok1 && ok2 && ok3 && ok4)) begin n_fail++; $display("FAIL drop_timeout %b%b%b%b want 1111", ok1, ok2, ok3, ok4); end
    n_tests++; if (bits.size() - start != NBITS || got !== exp)
      begin n_fail++; $display("FAIL drop_frame got %h want %h nbits %0d", got, exp, bits.size() - start); end
    n_tests++; if (ldac_falls - lf != 1 || done_cnt - dc != 1)
      begin n_fail++; $display("FAIL drop_ldac_once ldac %0d done %0d want 1 1", ldac_falls - lf, done_cnt - dc); end
    sf = sync_falls; lf = ldac_falls;
    tick(700);
    n_tests++; if (sync_falls != sf || ldac_falls != lf || busy !== 1'b0)
      begin n_fail++; $display("FAIL drop_quiet sync +%0d ldac +%0d busy %b want 0 0 0", sync_falls - sf, ldac_falls - lf, busy); end
  endtask

  task automatic test_reset_midframe();
    logic [NUM_CH*32-1:0] d;
    logic [NUM_CH-1:0] v;
    logic [143:0] got, exp;
    int start, lf, dc, nb;
    bit ok1, ok2, ok;
    apply_reset();
    d = rand_data(); v = NUM_CH'($urandom());
    s_axis.tdata = d; s_axis.tvalid = v; enable = 1'b1;
    lf = ldac_falls; dc = done_cnt;
    wait_sync_fall(20, ok1);
    start = bits.size();
    wait_bits(start, 70, 400, ok2);
    n_tests++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL rst_mid_setup %b%b want 11", ok1, ok2); end
    #2 a_rst = 1'b1;
    #1;
    n_tests++; if (dac_sync_n !== 1'b1 || dac_sclk !== 1'b0 || dac_ldac_n !== 1'b1 || busy !== 1'b0 || dac_sdo !== 1'b0)
      begin n_fail++; $display("FAIL rst_mid_async sync_n %b sclk %b ldac_n %b busy %b sdo %b want 1 0 1 0 0",
                               dac_sync_n, dac_sclk, dac_ldac_n, busy, dac_sdo); end
    enable = 1'b0;
    tick(3);
    a_rst = 1'b0;
    model_reset();
    tick(5);
    n_tests++; if (frame_count !== 32'd0 || ldac_falls != lf || done_cnt != dc)
      begin n_fail++; $display("FAIL rst_mid_aborted count %0d ldac +%0d done +%0d want 0 0 0", frame_count, ldac_falls - lf, done_cnt - dc); end
    do_frame(rand_data(), 6'b010101, 1'b0, got, nb, ok);
    exp = model_frame();
    n_tests++; if (!ok || nb != NBITS || got !== exp)
      begin n_fail++; $display("FAIL rst_mid_clean got %h want %h nbits %0d", got, exp, nb); end
    n_tests++; if (frame_count !== 32'd1) begin n_fail++; $display("FAIL rst_mid_count got %0d want 1", frame_count); end
  endtask

  initial begin
    a_rst = 1'b1; enable = 1'b0;
    s_axis.tdata = '0; s_axis.tvalid = '0;
    model_reset();
    test_reset();
    test_zero_frame();
    test_ordering();
    test_rounding();
    test_hold();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
